// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source select and
// load-type codes as presented by the memory stage.
package wb_pkg;

    // Writeback source select; the reserved code falls back to the ALU result.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    // Load-type codes; LD and LWU only have meaning on a 64-bit datapath.
    typedef enum logic [2:0] {
        LT_LB   = 3'd0,
        LT_LH   = 3'd1,
        LT_LW   = 3'd2,
        LT_LD   = 3'd3,
        LT_LBU  = 3'd4,
        LT_LHU  = 3'd5,
        LT_LWU  = 3'd6,
        LT_RSVD = 3'd7
    } load_type_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load extraction and extension. Picks the byte/half/word
// field out of the aligned memory word using the low address bits and
// sign- or zero-extends it to XLEN. Misaligned half/word offsets are not
// trapped: the low offset bits are simply dropped, so the lower-aligned
// field is returned.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_out,
    input  logic [2:0]      load_type,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] load_data
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [2:0]      byte_idx;
    logic [1:0]      half_idx;
    logic            word_idx;
    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [XLEN-1:0] word_shift;
    logic [7:0]      byte_f;
    logic [15:0]     half_f;
    logic [31:0]     word_f;

    // Lane indices: on a 32-bit datapath only four byte lanes exist, so the
    // top address bit is ignored and word selection collapses to lane 0.
    always_comb begin
        byte_idx = IS_RV64 ? addr_lo : {1'b0, addr_lo[1:0]};
        half_idx = byte_idx[2:1];
        word_idx = IS_RV64 ? addr_lo[2] : 1'b0;
    end

    // Shift the requested lane down to bit 0 so the field is always [N-1:0];
    // this keeps every part-select in range for both datapath widths.
    assign byte_shift = mem_out >> {byte_idx, 3'b000};
    assign half_shift = mem_out >> {half_idx, 4'b0000};
    assign word_shift = mem_out >> {word_idx, 5'b00000};

    assign byte_f = byte_shift[7:0];
    assign half_f = half_shift[15:0];
    assign word_f = word_shift[31:0];

    // Extension by load type; anything without a 64-bit meaning on a 32-bit
    // datapath (LD, LWU, reserved) behaves as a plain LW.
    always_comb begin
        load_data = XLEN'($signed(word_f));
        case (load_type_e'(load_type))
            LT_LB:   load_data = XLEN'($signed(byte_f));
            LT_LH:   load_data = XLEN'($signed(half_f));
            LT_LW:   load_data = XLEN'($signed(word_f));
            LT_LBU:  load_data = XLEN'(byte_f);
            LT_LHU:  load_data = XLEN'(half_f);
            LT_LWU:  load_data = IS_RV64 ? XLEN'(word_f) : XLEN'($signed(word_f));
            LT_LD:   load_data = IS_RV64 ? mem_out : XLEN'($signed(word_f));
            default: load_data = XLEN'($signed(word_f));
        endcase
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage. Holds a single instruction between the memory
// stage and the register file, drives the register-file write port and a
// forwarding entry, and counts retired instructions. Halt freezes the held
// entry; flush kills it (and anything offered in the same cycle).
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ms_valid,
    output logic             ws_ready,
    input  logic [XLEN-1:0]  ms_alu_result,
    input  logic [XLEN-1:0]  ms_mem_out,
    input  logic [XLEN-1:0]  ms_pc_plus4,
    input  logic [1:0]       ms_wb_sel,
    input  logic [2:0]       ms_load_type,
    input  logic [2:0]       ms_addr_lo,
    input  logic             ms_reg_wen,
    input  logic [RA_W-1:0]  ms_rd,
    input  logic             ws_halt,
    input  logic             ws_flush,
    output logic             ws_reg_wen,
    output logic [RA_W-1:0]  ws_rd,
    output logic [XLEN-1:0]  ws_reg_wdata,
    output logic             ws_fwd_valid,
    output logic [RA_W-1:0]  ws_fwd_rd,
    output logic [XLEN-1:0]  ws_fwd_data,
    output logic [CNT_W-1:0] ws_retire_cnt
);

    logic             valid_q, valid_d;
    logic             wen_q,   wen_d;
    logic [RA_W-1:0]  rd_q,    rd_d;
    logic [XLEN-1:0]  data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             accept;
    logic             commit;
    logic             rd_nonzero;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  sel_data;

    wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .mem_out   (ms_mem_out),
        .load_type (ms_load_type),
        .addr_lo   (ms_addr_lo),
        .load_data (load_data)
    );

    // Writeback source mux; the reserved select code reads the ALU result.
    always_comb begin
        sel_data = ms_alu_result;
        case (wb_sel_e'(ms_wb_sel))
            WB_ALU:  sel_data = ms_alu_result;
            WB_MEM:  sel_data = load_data;
            WB_PC4:  sel_data = ms_pc_plus4;
            default: sel_data = ms_alu_result;
        endcase
    end

    // Handshake: the held entry retires unless halted or flushed, and a new
    // one may enter whenever the slot is empty or being vacated this cycle.
    assign commit     = valid_q && !ws_halt && !ws_flush;
    assign ws_ready   = !valid_q || commit;
    assign accept     = ms_valid && ws_ready && !ws_flush;
    assign rd_nonzero = (rd_q != '0);

    // Next-state: payload fields change only on accept; flush always empties
    // the slot and takes priority over halt.
    always_comb begin
        wen_d  = wen_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (ws_flush) begin
            valid_d = 1'b0;
        end else begin
            valid_d = accept || (valid_q && !commit);
        end
        if (accept) begin
            wen_d  = ms_reg_wen;
            rd_d   = ms_rd;
            data_d = sel_data;
        end
        cnt_d = commit ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    // Stage register and retire counter; reset discards the held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register-file port: writes to x0 are suppressed here so the register
    // file never has to special-case them.
    assign ws_reg_wen    = commit && wen_q && rd_nonzero;
    assign ws_rd         = rd_q;
    assign ws_reg_wdata  = data_q;

    // Forwarding stays visible while halted so younger instructions can
    // still bypass from the held entry.
    assign ws_fwd_valid  = valid_q && wen_q && rd_nonzero;
    assign ws_fwd_rd     = rd_q;
    assign ws_fwd_data   = data_q;

    assign ws_retire_cnt = cnt_q;

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameter XLEN, default 32: data path width; legal values are 32 and 64.
REQ-002 Parameter RA_W, default 5: register address width.
REQ-003 Parameter CNT_W, default 32: retire counter width.
REQ-004 Port list SHALL be exactly the following:
- clk  in  1  clock; all state rises on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- ms_valid  in  1  memory stage presents an instruction.
- ws_ready  out  1  the stage can accept this cycle.
- ms_alu_result  in  XLEN  ALU result.
- ms_mem_out  in  XLEN  raw aligned memory word.
- ms_pc_plus4  in  XLEN  link value for JAL/JALR.
- ms_wb_sel  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved.
- ms_load_type  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 3 LD (XLEN=64 only), 6 LWU (XLEN=64 only).
- ms_addr_lo  in  3  low effective-address bits.
- ms_reg_wen  in  1  instruction writes rd.
- ms_rd  in  RA_W  destination register.
- ws_halt  in  1  debug hold; blocks commit.
- ws_flush  in  1  kill the held instruction.
- ws_reg_wen  out  1  register file write enable.
- ws_rd  out  RA_W  register file write address.
- ws_reg_wdata  out  XLEN  register file write data.
- ws_fwd_valid  out  1  forwarding entry is valid.
- ws_fwd_rd  out  RA_W  forwarding destination.
- ws_fwd_data  out  XLEN  forwarding value.
- ws_retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-005 Stage SHALL hold one instruction in a register: valid_q, wen_q, rd_q, data_q.
REQ-006 accept = ms_valid && ws_ready && !ws_flush; on accept, the stage SHALL capture the selected and extended data at the posedge, giving 1-cycle latency.
REQ-007 commit = valid_q && !ws_halt && !ws_flush.
REQ-008 ws_ready = !valid_q || commit, which allows back-to-back flow at one instruction per cycle.
REQ-009 Data select SHALL follow ms_wb_sel:
- 0 or 3: ALU result.
- 1: load-extended memory data.
- 2: pc_plus4.
REQ-010 Load extension SHALL extract fields as follows:
- Byte: ms_mem_out[8*addr_lo +: 8].
- Half: ms_mem_out[16*addr_lo[2:1] +: 16].
- Word: addr_lo[2] selects the word (XLEN=64); addr_lo is ignored for XLEN=32.
- LB, LH and LW sign-extend; LBU, LHU and LWU zero-extend.
- LD passes the value through unchanged.
- LD, LWU or reserved codes at XLEN=32 SHALL behave as LW.
REQ-011 Misaligned half/word offsets SHALL NOT be checked; the lower-aligned field is used.
REQ-012 ws_reg_wen = commit && wen_q && (rd_q != 0), so writes to x0 are suppressed.
REQ-013 ws_rd = rd_q and ws_reg_wdata = data_q at all times; both come directly from flops.
REQ-014 ws_fwd_valid = valid_q && wen_q && (rd_q != 0), independent of ws_halt; ws_fwd_rd = rd_q; ws_fwd_data = data_q.
REQ-015 Valid-state transitions:
- Flush SHALL clear valid_q at the next edge.
- Otherwise valid_q_next = accept || (valid_q && !commit).
REQ-016 While halted, the held contents SHALL be stable and no new instruction SHALL be accepted.
REQ-017 ws_flush and ws_halt asserted together: flush wins, no write occurs, and valid_q clears.
REQ-018 ws_flush and ms_valid asserted together: the incoming instruction SHALL be dropped (REQ-006).
REQ-019 ws_retire_cnt SHALL increment by 1 on every commit, including instructions with wen=0, and wrap modulo 2^CNT_W.
REQ-020 Fields wen_q, rd_q and data_q SHALL be updated only on accept.

Reset
REQ-021 rst_n low SHALL asynchronously clear valid_q, wen_q, rd_q, data_q and ws_retire_cnt to 0.
REQ-022 While rst_n is low: ws_ready=1, ws_reg_wen=0, ws_fwd_valid=0 and all data outputs are 0.
REQ-023 Reset asserted mid-operation SHALL discard the held instruction without a write.
REQ-024 Reset release SHALL be synchronised externally; the stage requires no extra cycles after release.

Structure
REQ-025 Package wb_pkg SHALL hold the wb_sel codes (WB_ALU, WB_MEM, WB_PC4) and load-type codes (LT_LB, LT_LH, LT_LW, LT_LD, LT_LBU, LT_LHU, LT_LWU).
REQ-026 Load extraction and extension SHALL be implemented in the combinational sub-module wb_load_ext, parametrised by XLEN.
REQ-027 The top level SHALL contain only the source mux, the stage register, the control logic and the counter.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- LB, mem_out=0x12345680, addr_lo=0, rd=5 -> one cycle later ws_reg_wen=1, ws_rd=5, wdata=0xFFFFFF80.
- LHU, mem_out=0x8001_7FFF, addr_lo=2 -> wdata=0x00008001; LH with the same inputs -> 0xFFFF8001.
- JAL, wb_sel=2, pc_plus4=0x100, rd=0 -> ws_reg_wen=0 and ws_fwd_valid=0; ws_retire_cnt increments by 1.
- Three back-to-back ALU instructions with ms_valid held high -> three consecutive write cycles, ws_ready constantly 1, counter +3.
- ws_halt held 4 cycles with an entry present -> ws_ready=0, no write, ws_fwd_valid=1 and stable; write occurs in the cycle after halt drops.
- ws_flush with ws_halt and ms_valid all high -> no write, the incoming instruction is dropped, valid_q=0 next cycle; rst_n pulsed low mid-hold -> all outputs 0 asynchronously and counter=0.
